// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and the load/store datapath. A grant FSM sequences one access at a time over
// a req/ready handshake. Store lanes are replicated with matching byte enables,
// and load data is extracted and extended.
// Optional build macro ARB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive data
// grants with fetch waiting, fetch wins the next arbitration. With the macro
// undefined, data always has priority and no counter exists.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [2:0]  dm_type,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GNT_D  = 3'd1,
        GNT_I  = 3'd2,
        RESP_D = 3'd3,
        RESP_I = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  type_r;
    logic [1:0]  off_r;
    logic        fault_r;
    logic        data_fault;
    logic        starve;
    logic        grant_d;
    logic        grant_f;
    logic        grant_i;

    // Misaligned halfword/word accesses and the unused funct3 codes are faults.
    function automatic logic access_fault(input logic [2:0] t, input logic [1:0] o);
        logic f;
        case (t)
            3'b000, 3'b100: f = 1'b0;
            3'b001, 3'b101: f = o[0];
            3'b010:         f = (o != 2'b00);
            default:        f = 1'b1;
        endcase
        return f;
    endfunction

    // Byte enables for an aligned access; loads use the same lanes as stores.
    function automatic logic [3:0] lane_be(input logic [2:0] t, input logic [1:0] o);
        logic [3:0] be;
        case (t[1:0])
            2'b00:   be = 4'b0001 << o;
            2'b01:   be = o[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Right-aligned store data is copied into every lane the size can occupy.
    function automatic logic [31:0] lane_wdata(input logic [2:0] t, input logic [31:0] w);
        logic [31:0] d;
        case (t[1:0])
            2'b00:   d = {4{w[7:0]}};
            2'b01:   d = {2{w[15:0]}};
            default: d = w;
        endcase
        return d;
    endfunction

    // Select the addressed byte/halfword and sign- or zero-extend per funct3.
    function automatic logic [31:0] load_extend(input logic [2:0] t, input logic [1:0] o,
                                                input logic [31:0] w);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        sh = w >> {o, 3'b000};
        b  = sh[7:0];
        h  = o[1] ? w[31:16] : w[15:0];
        case (t)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign data_fault = access_fault(dm_type, dm_addr[1:0]);

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign starve = if_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Count data grants taken while fetch is waiting; any fetch grant or idle fetch clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (!if_req || grant_i) begin
                starve_cnt <= '0;
            end else if (grant_d || grant_f) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    assign starve = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection: data first unless fetch is being starved; faults skip memory.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (dm_req && !starve) begin
                    state_nxt = data_fault ? RESP_D : GNT_D;
                end else if (if_req) begin
                    state_nxt = GNT_I;
                end
            end
            GNT_D:   if (mem_ready) state_nxt = RESP_D;
            GNT_I:   if (mem_ready) state_nxt = RESP_I;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the registered state, so reset clears mem_req immediately.
    always_comb begin
        mem_req  = (state == GNT_D) || (state == GNT_I);
        dm_done  = (state == RESP_D);
        if_valid = (state == RESP_I);
        dm_fault = (state == RESP_D) && fault_r;
    end

    assign grant_d = (state == IDLE) && (state_nxt == GNT_D);
    assign grant_f = (state == IDLE) && (state_nxt == RESP_D);
    assign grant_i = (state == IDLE) && (state_nxt == GNT_I);

    // Register the granted request into the memory-side outputs; they hold outside a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            type_r    <= 3'd0;
            off_r     <= 2'd0;
            fault_r   <= 1'b0;
        end else if (grant_d) begin
            mem_we    <= dm_we;
            mem_addr  <= dm_addr & 32'hFFFF_FFFC;
            mem_be    <= lane_be(dm_type, dm_addr[1:0]);
            mem_wdata <= lane_wdata(dm_type, dm_wdata);
            type_r    <= dm_type;
            off_r     <= dm_addr[1:0];
            fault_r   <= 1'b0;
        end else if (grant_f) begin
            fault_r   <= 1'b1;
        end else if (grant_i) begin
            mem_we    <= 1'b0;
            mem_addr  <= if_addr & 32'hFFFF_FFFC;
            mem_be    <= 4'b1111;
        end
    end

    // Capture read data on the completing memory cycle; a fault returns zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_rdata <= 32'd0;
            if_rdata <= 32'd0;
        end else begin
            if (grant_f) begin
                dm_rdata <= 32'd0;
            end
            if ((state == GNT_D) && mem_ready) begin
                dm_rdata <= load_extend(type_r, off_r, mem_rdata);
            end
            if ((state == GNT_I) && mem_ready) begin
                if_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model
// and a per-cycle compare process.
module tb_mem_port_arbiter;

    localparam int TB_LIMIT = 2;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_type;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        dm_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_chk = 0;
    int n_fail = 0;

    mem_port_arbiter #(.STARVE_LIMIT(TB_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_type(dm_type), .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_fault(dm_fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic m_is_fault(input logic [2:0] t, input logic [31:0] a);
        int ti;
        ti = int'(t);
        if (ti == 3 || ti >= 6) return 1'b1;
        if ((ti % 4) == 1 && a[0]) return 1'b1;
        if (ti == 2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
        int o;
        o = int'(a % 4);
        if (t == 3'd0 || t == 3'd4) return 4'(1 << o);
        if (t == 3'd1 || t == 3'd5) return (o == 0) ? 4'd3 : 4'd12;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] w);
        if (t == 3'd0) return (w % 256) * 32'h0101_0101;
        if (t == 3'd1) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] a,
                                           input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w / (32'd1 << (8 * (a % 4)))) % 256;
        h = (w / (32'd1 << (16 * ((a % 4) / 2)))) % 65536;
        case (t)
            3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // ---------------- transaction-level model ----------------
    localparam int P_IDLE = 0;
    localparam int P_GNT  = 1;
    localparam int P_RESP = 2;

    int          m_phase;
    int          m_cnt;
    logic        m_own;      // 1 = fetch owns the port
    logic        m_fault;
    logic        m_we;
    logic [2:0]  m_t;
    logic [31:0] m_a;
    logic [31:0] m_wd;
    logic [31:0] m_ia;
    logic [31:0] m_drd;
    logic [31:0] m_ird;
    wire         fetch_first = STARVE_ON && if_req && (m_cnt == TB_LIMIT);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= P_IDLE;
            m_cnt   <= 0;
            m_own   <= 1'b0;
            m_fault <= 1'b0;
            m_drd   <= 32'd0;
            m_ird   <= 32'd0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (dm_req && !fetch_first) begin
                        m_own   <= 1'b0;
                        m_we    <= dm_we;
                        m_t     <= dm_type;
                        m_a     <= dm_addr;
                        m_wd    <= dm_wdata;
                        m_fault <= m_is_fault(dm_type, dm_addr);
                        if (m_is_fault(dm_type, dm_addr)) begin
                            m_drd   <= 32'd0;
                            m_phase <= P_RESP;
                        end else begin
                            m_phase <= P_GNT;
                        end
                        if (if_req) m_cnt <= m_cnt + 1;
                        else m_cnt <= 0;
                    end else if (if_req) begin
                        m_own   <= 1'b1;
                        m_fault <= 1'b0;
                        m_ia    <= if_addr;
                        m_phase <= P_GNT;
                        m_cnt   <= 0;
                    end else begin
                        m_cnt <= 0;
                    end
                end
                P_GNT: begin
                    if (mem_ready) begin
                        if (m_own) m_ird <= mem_rdata;
                        else m_drd <= m_load(m_t, m_a, mem_rdata);
                        m_phase <= P_RESP;
                    end
                end
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("mem_req", mem_req, m_phase == P_GNT);
            chk("dm_done", dm_done, m_phase == P_RESP && !m_own);
            chk("if_valid", if_valid, m_phase == P_RESP && m_own);
            chk("dm_fault", dm_fault, m_phase == P_RESP && !m_own && m_fault);
            chk("single_pulse", dm_done & if_valid, 0);
            if (m_phase == P_GNT) begin
                chk("mem_addr", mem_addr, (m_own ? m_ia : m_a) & 32'hFFFF_FFFC);
                chk("mem_be", mem_be, m_own ? 4'hF : m_be(m_t, m_a));
                chk("mem_we", mem_we, m_own ? 1'b0 : m_we);
                if (!m_own && m_we) chk("mem_wdata", mem_wdata, m_wdata(m_t, m_wd));
            end
            if (dm_done) chk("dm_rdata", dm_rdata, m_drd);
            if (if_valid) chk("if_rdata", if_rdata, m_ird);
        end
    end

    // ---------------- memory responder ----------------
    int waits_cfg = 0;
    int wcnt = 0;

    always @(negedge clk) begin
        if (mem_req) begin
            if (wcnt == 0) begin
                mem_ready = 1'b1;
            end else begin
                mem_ready = 1'b0;
                wcnt = wcnt - 1;
            end
        end else begin
            mem_ready = 1'b0;
            wcnt = waits_cfg;
        end
    end

    // ---------------- directed stimulus ----------------
    int          r_lat;
    int          r_nreq;
    logic [31:0] r_rd;
    logic        r_flt;
    logic [3:0]  r_be;
    logic [31:0] r_wd;
    logic [31:0] r_ad;
    logic        r_we;

    task automatic data_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] t, input int waits, input logic [31:0] rd);
        int c;
        waits_cfg = waits;
        @(negedge clk);
        mem_rdata = rd;
        dm_we = we; dm_addr = a; dm_wdata = wd; dm_type = t; dm_req = 1'b1;
        r_nreq = 0;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            if (mem_req) begin
                if (r_nreq == 0) begin
                    r_be = mem_be; r_wd = mem_wdata; r_ad = mem_addr; r_we = mem_we;
                end
                r_nreq++;
            end
        end while (!dm_done && c < 40);
        chk("data_op_completes", dm_done, 1);
        r_lat = c; r_rd = dm_rdata; r_flt = dm_fault;
        dm_req = 1'b0;
    endtask

    task automatic fetch_op(input logic [31:0] a, input logic [31:0] rd);
        int c;
        waits_cfg = 0;
        @(negedge clk);
        mem_rdata = rd;
        if_addr = a; if_req = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            if (mem_req) begin
                r_be = mem_be; r_ad = mem_addr;
            end
        end while (!if_valid && c < 40);
        chk("fetch_completes", if_valid, 1);
        r_lat = c; r_rd = if_rdata;
        if_req = 1'b0;
    endtask

    initial begin
        int c;
        int cd;
        int cv;
        int seq [3];
        logic seen;

        rst = 1'b1;
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        dm_type = 0; mem_rdata = 0; mem_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_dm_done", dm_done, 0);
        chk("rst_dm_fault", dm_fault, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_rdata", if_rdata, 0);
        rst = 1'b0;

        // LW, zero-wait memory
        data_op(1'b0, 32'h100, 32'h0, 3'b010, 0, 32'hDEAD_BEEF);
        chk("lw_latency", r_lat, 2);
        chk("lw_rdata", r_rd, 32'hDEAD_BEEF);
        chk("lw_addr", r_ad, 32'h100);
        chk("lw_be", r_be, 4'b1111);
        chk("lw_req_cycles", r_nreq, 1);
        chk("lw_fault", r_flt, 0);

        // LB / LBU at byte 3
        data_op(1'b0, 32'h103, 32'h0, 3'b000, 0, 32'h8011_2233);
        chk("lb_rdata", r_rd, 32'hFFFF_FF80);
        chk("lb_be", r_be, 4'b1000);
        data_op(1'b0, 32'h103, 32'h0, 3'b100, 0, 32'h8011_2233);
        chk("lbu_rdata", r_rd, 32'h0000_0080);
        chk("lbu_be", r_be, 4'b1000);

        // LH / LHU upper half
        data_op(1'b0, 32'h102, 32'h0, 3'b001, 0, 32'h8011_2233);
        chk("lh_rdata", r_rd, 32'hFFFF_8011);
        data_op(1'b0, 32'h102, 32'h0, 3'b101, 0, 32'h8011_2233);
        chk("lhu_rdata", r_rd, 32'h0000_8011);

        // SH upper half, SB lane 1
        data_op(1'b1, 32'h202, 32'h0000_ABCD, 3'b001, 0, 32'h0);
        chk("sh_be", r_be, 4'b1100);
        chk("sh_wdata", r_wd, 32'hABCD_ABCD);
        chk("sh_we", r_we, 1);
        chk("sh_addr", r_ad, 32'h200);
        data_op(1'b1, 32'h101, 32'h1234_56A5, 3'b000, 0, 32'h0);
        chk("sb_be", r_be, 4'b0010);
        chk("sb_wdata", r_wd, 32'hA5A5_A5A5);

        // Faults: misaligned SW, illegal funct3
        data_op(1'b1, 32'h301, 32'h1111_1111, 3'b010, 0, 32'h5555_5555);
        chk("sw_mis_latency", r_lat, 1);
        chk("sw_mis_fault", r_flt, 1);
        chk("sw_mis_req_cycles", r_nreq, 0);
        chk("sw_mis_rdata", r_rd, 0);
        data_op(1'b0, 32'h300, 32'h0, 3'b111, 0, 32'h5555_5555);
        chk("t111_latency", r_lat, 1);
        chk("t111_fault", r_flt, 1);
        chk("t111_req_cycles", r_nreq, 0);

        // Wait states: 3 not-ready cycles
        data_op(1'b0, 32'h104, 32'h0, 3'b010, 3, 32'h0BAD_F00D);
        chk("wait_req_cycles", r_nreq, 4);
        chk("wait_latency", r_lat, 5);
        chk("wait_rdata", r_rd, 32'h0BAD_F00D);

        // Fetch alone
        fetch_op(32'h1003, 32'hCAFE_F00D);
        chk("fetch_latency", r_lat, 2);
        chk("fetch_rdata", r_rd, 32'hCAFE_F00D);
        chk("fetch_addr", r_ad, 32'h1000);
        chk("fetch_be", r_be, 4'b1111);

        // Contention: data first, fetch right after
        waits_cfg = 0;
        @(negedge clk);
        mem_rdata = 32'h1234_5678;
        dm_we = 0; dm_addr = 32'h400; dm_type = 3'b010; dm_req = 1;
        if_addr = 32'h800; if_req = 1;
        c = 0; cd = 0; cv = 0;
        while ((cd == 0 || cv == 0) && c < 40) begin
            @(negedge clk);
            c++;
            if (dm_done) begin cd = c; dm_req = 0; end
            if (if_valid) begin cv = c; if_req = 0; end
        end
        chk("contend_data_done", cd, 2);
        chk("contend_fetch_valid", cv, 5);

        // Continuous data requests with fetch waiting
        waits_cfg = 0;
        @(negedge clk);
        mem_rdata = 32'h0F0F_0F0F;
        dm_we = 0; dm_addr = 32'h500; dm_type = 3'b010; dm_req = 1;
        if_addr = 32'h900; if_req = 1;
        for (int k = 0; k < 3; k++) begin
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (!dm_done && !if_valid && c < 40);
            seq[k] = if_valid ? 1 : (dm_done ? 0 : 2);
            if (dm_done) dm_req = 0;
            if (if_valid) if_req = 0;
            @(negedge clk);
            dm_req = 1;
        end
        chk("starve_grant0", seq[0], 0);
        chk("starve_grant1", seq[1], 0);
        chk("starve_grant2", seq[2], STARVE_ON ? 1 : 0);
        c = 0;
        while ((dm_req || if_req) && c < 40) begin
            @(negedge clk);
            c++;
            if (dm_done) dm_req = 0;
            if (if_valid) if_req = 0;
        end
        chk("starve_drain_in_time", c < 40, 1);

        // Reset in the middle of a grant
        waits_cfg = 5;
        @(negedge clk);
        mem_rdata = 32'h7777_7777;
        dm_we = 0; dm_addr = 32'h600; dm_type = 3'b010; dm_req = 1;
        repeat (2) @(negedge clk);
        chk("pre_rst_mem_req", mem_req, 1);
        #2 rst = 1'b1;
        #1 chk("rst_async_mem_req", mem_req, 0);
        dm_req = 0;
        waits_cfg = 0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (dm_done || if_valid) seen = 1'b1;
        end
        chk("rst_no_done", seen, 0);
        chk("rst_rdata_cleared", dm_rdata, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch (read-only) and the load/store datapath (read/write, typed by funct3 memType).
- Sequences each access with a grant FSM and a req/ready handshake to memory.
- Generates byte enables and write-lane replication for stores, and extracts and extends loaded data.
- Sits between the CPU pipeline (fetch stage, MEM stage driven by memRead/memWrite/memType) and the memory controller.

Parameters:
- STARVE_LIMIT, 4, number of consecutive data grants while fetch waits before fetch is forced to win. Used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_req  input  1  fetch request; held until if_valid.
- if_addr  input  32  fetch address; bits [1:0] ignored.
- if_rdata  output  32  fetched word; valid while if_valid.
- if_valid  output  1  one-cycle fetch completion pulse.
- dm_req  input  1  data request; held, with its operands, until dm_done.
- dm_we  input  1  1 = store, 0 = load.
- dm_addr  input  32  byte address.
- dm_wdata  input  32  store data, right-aligned.
- dm_type  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- dm_rdata  output  32  extended load result; valid while dm_done.
- dm_done  output  1  one-cycle data completion pulse.
- dm_fault  output  1  pulses with dm_done on misaligned or illegal access.
- mem_req  output  1  memory request.
- mem_we  output  1  memory write.
- mem_addr  output  32  word address, {addr[31:2], 2'b00}.
- mem_be  output  4  byte-lane enables.
- mem_wdata  output  32  lane-replicated store data.
- mem_rdata  input  32  memory read word; valid when mem_ready.
- mem_ready  input  1  access completes on a cycle with mem_req && mem_ready.

Behaviour:
- Reset values: state IDLE; all outputs 0; starvation counter 0.
- Reset acts immediately, including mid-access: mem_req drops asynchronously and any in-flight access is abandoned with no completion pulse.
- FSM states: IDLE, GNT_D, GNT_I, RESP_D, RESP_I.
- IDLE, selection order:
  - dm_req with a fault → RESP_D, with dm_fault=1 and no memory access.
  - dm_req → GNT_D.
  - else if_req → GNT_I.
  - Simultaneous requests: data wins, except as modified by the optional feature.
- Grant: request fields are registered on entry. mem_* outputs are registered and stable through the whole GNT state. mem_req=1 for every GNT cycle.
- GNT_x:
  - Waits with no timeout while mem_ready=0.
  - On mem_ready=1, captures mem_rdata and moves to RESP_x. mem_req is 0 from that edge.
- RESP_D / RESP_I:
  - dm_done or if_valid is 1 for exactly this cycle, with rdata registered.
  - No new grant is made in a RESP state.
  - Next state is always IDLE.
  - The requester must drop req during its RESP cycle.
- Minimum latency with zero-wait memory: req seen in IDLE at cycle 0 → mem_req at cycle 1 → done at cycle 2 → IDLE at cycle 3.
- Fault conditions (data only):
  - dm_type 011, 110 or 111.
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - On fault: dm_rdata=0 and dm_fault=1 with dm_done.
- Fetch is never faulted; mem_be=1111.
- Byte enables, where o = addr[1:0]:
  - B/BU: 1<<o.
  - H/HU: 0011 if o=0, 1100 if o=2.
  - W: 1111.
  - Loads use the same mem_be as stores.
- Store data: B replicates wdata[7:0] to all 4 lanes. H replicates wdata[15:0] to both halves. W passes through unchanged.
- Load data: select byte o or halfword o[1].
  - B and H sign-extend.
  - BU and HU zero-extend.
  - W passes through unchanged.
- Outputs unused in a given state (mem_* outside GNT, rdata outside RESP) hold their last value.
- Done pulses are never asserted together.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A counter increments on each data grant made while if_req=1.
  - When the counter equals STARVE_LIMIT and if_req=1 in IDLE, fetch wins over a pending dm_req.
  - The counter clears on every fetch grant, and when if_req=0 in IDLE.
  - Counter width is $clog2(STARVE_LIMIT+1).
- Undefined: strict data priority; no counter logic is synthesized.

Test Plan:
- LW single access: dm_req with addr 0x100, zero-wait memory, mem_rdata 0xDEADBEEF → mem_addr 0x100, mem_be 1111, mem_req for 1 cycle; dm_done at cycle 2; dm_rdata 0xDEADBEEF.
- LB and LBU: addr 0x103, mem_rdata 0x80112233 → LB gives 0xFFFFFF80, LBU gives 0x00000080, mem_be 1000 for both.
- SH: addr 0x202, wdata 0x0000ABCD → mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1, mem_addr 0x200.
- Faults: SW at 0x301 → dm_done and dm_fault at cycle 1, mem_req never asserted. Same result for dm_type 111.
- Contention and wait states:
  - if_req and dm_req together → data granted first.
  - mem_ready held low for 3 cycles → mem_req high for 4 cycles with stable mem_addr.
  - Fetch is granted in the IDLE following RESP_D; if_valid arrives later.
- Starvation and reset:
  - With ARB_STARVE_GUARD_EN and STARVE_LIMIT=2, continuous dm_req plus if_req → fetch granted after 2 data grants.
  - rst asserted mid-GNT → mem_req drops the same cycle and no done pulse follows.
